// File: rtl/pattern_detector_pkg.sv
// Shared types and defaults for the programmable serial pattern detector.
// The reset configuration reproduces the legacy three-ones detector.
package pattern_detector_pkg;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    localparam int   DEFAULT_LEN     = 3;
    localparam logic DEFAULT_OVERLAP = 1'b1;
    localparam int   MASK_W          = 32;

    // Ones in bits [len-1:0]; callers truncate to their own pattern width.
    function automatic logic [MASK_W-1:0] len_mask(input logic [5:0] len);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (i < int'(len)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/pattern_detector_p_history.sv
// Sample history: shift register of accepted bits plus a fill counter
// saturating at MAX_LEN. Exposes the post-shift values for same-cycle compare.
module pd_history
    import pattern_detector_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               shift_en,
    input  logic               clr,
    input  logic               x,
    output logic [MAX_LEN-1:0] shifted_hist,
    output logic [LEN_W-1:0]   shifted_fill
);

    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;

    always_comb begin
        shifted_hist = {hist[MAX_LEN-2:0], x};
        shifted_fill = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
    end

    // NOTE: nRST is synchronous and active-high here, so it sits inside the
    // clocked branch and the block is sensitive to CLK alone.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            hist <= '0;
            fill <= '0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= shifted_hist;
            fill <= shifted_fill;
        end
    end

endmodule

// File: rtl/pattern_detector_p.sv
// Programmable serial pattern detector: configuration registers, comparator,
// FILL/ARMED state, registered match pulse, saturating counter, sticky error.
module pattern_detector_p
    import pattern_detector_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               EN,
    input  logic               X,
    input  logic               CFG_LOAD,
    input  logic [MAX_LEN-1:0] CFG_PATTERN,
    input  logic [LEN_W-1:0]   CFG_LEN,
    input  logic               CFG_OVERLAP,
    input  logic               CLR_CNT,
    output logic               Y,
    output logic [CNT_W-1:0]   MATCH_CNT,
    output logic               CFG_ERR,
    output logic               ARMED
);

    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    state_t             state_q;
    logic               y_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;

    logic [MAX_LEN-1:0] shifted_hist;
    logic [LEN_W-1:0]   shifted_fill;
    logic [MAX_LEN-1:0] mask;
    logic               cfg_ok;
    logic               accept;
    logic               hit;
    logic               hit_accepted;
    logic               hist_clr;

    always_comb begin
        cfg_ok       = (CFG_LEN != '0) && (CFG_LEN <= LEN_W'(MAX_LEN));
        accept       = EN && !CFG_LOAD;
        mask         = MAX_LEN'(len_mask(6'(len_q)));
        hit          = (shifted_fill >= len_q) &&
                       ((shifted_hist & mask) == (pattern_q & mask));
        hit_accepted = accept && hit;
        // Non-overlapping mode restarts the fill so the next match needs LEN fresh bits.
        hist_clr     = (CFG_LOAD && cfg_ok) || (hit_accepted && !overlap_q);
    end

    pd_history #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_history (
        .CLK          (CLK),
        .nRST         (nRST),
        .shift_en     (accept),
        .clr          (hist_clr),
        .x            (X),
        .shifted_hist (shifted_hist),
        .shifted_fill (shifted_fill)
    );

    always_ff @(posedge CLK) begin
        if (nRST) begin
            pattern_q <= MAX_LEN'(3'b111);
            len_q     <= LEN_W'(DEFAULT_LEN);
            overlap_q <= DEFAULT_OVERLAP;
            state_q   <= ST_FILL;
            y_q       <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            if (CFG_LOAD) begin
                y_q <= 1'b0;
                if (cfg_ok) begin
                    pattern_q <= CFG_PATTERN;
                    len_q     <= CFG_LEN;
                    overlap_q <= CFG_OVERLAP;
                    state_q   <= ST_FILL;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (EN) begin
                y_q <= hit;
                if (hit && !overlap_q)
                    state_q <= ST_FILL;
                else if (shifted_fill >= len_q)
                    state_q <= ST_ARMED;
                else
                    state_q <= ST_FILL;
            end else begin
                y_q <= 1'b0;
            end

            // Clear then count: a match coinciding with CLR_CNT leaves one.
            if (CLR_CNT)
                cnt_q <= hit_accepted ? CNT_W'(1) : '0;
            else if (hit_accepted && (cnt_q != '1))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign Y         = y_q;
    assign MATCH_CNT = cnt_q;
    assign CFG_ERR   = err_q;
    assign ARMED     = (state_q == ST_ARMED);

endmodule

// File: tb/tb_pattern_detector_p.sv
// Scoreboard bench for pattern_detector_p: expected Y pushed per driven cycle,
// popped after the edge. A second instance with CNT_W=2 covers saturation.
module tb_pattern_detector_p;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic               CLK = 1'b0;
    logic               nRST;
    logic               EN;
    logic               X;
    logic               CFG_LOAD;
    logic [MAX_LEN-1:0] CFG_PATTERN;
    logic [LEN_W-1:0]   CFG_LEN;
    logic               CFG_OVERLAP;
    logic               CLR_CNT;

    logic               Y;
    logic [7:0]         MATCH_CNT;
    logic               CFG_ERR;
    logic               ARMED;

    logic               y_s;
    logic [1:0]         cnt_s;
    logic               err_s;
    logic               armed_s;

    int   vectors     = 0;
    int   miscompares = 0;
    logic exp_q[$];

    always #5 CLK = ~CLK;

    pattern_detector_p #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
        .CLK(CLK), .nRST(nRST), .EN(EN), .X(X), .CFG_LOAD(CFG_LOAD),
        .CFG_PATTERN(CFG_PATTERN), .CFG_LEN(CFG_LEN), .CFG_OVERLAP(CFG_OVERLAP),
        .CLR_CNT(CLR_CNT), .Y(Y), .MATCH_CNT(MATCH_CNT), .CFG_ERR(CFG_ERR),
        .ARMED(ARMED)
    );

    pattern_detector_p #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_sat (
        .CLK(CLK), .nRST(nRST), .EN(EN), .X(X), .CFG_LOAD(CFG_LOAD),
        .CFG_PATTERN(CFG_PATTERN), .CFG_LEN(CFG_LEN), .CFG_OVERLAP(CFG_OVERLAP),
        .CLR_CNT(CLR_CNT), .Y(y_s), .MATCH_CNT(cnt_s), .CFG_ERR(err_s),
        .ARMED(armed_s)
    );

    // Drive one cycle of stimulus, record the Y expected after the edge,
    // then sample #1 past the edge with strobes returned to idle.
    task automatic drive(input logic rst_v, input logic en_v, input logic x_v,
                         input logic load_v, input logic clr_v, input logic exp_y);
        nRST     = rst_v;
        EN       = en_v;
        X        = x_v;
        CFG_LOAD = load_v;
        CLR_CNT  = clr_v;
        exp_q.push_back(exp_y);
        @(posedge CLK);
        #1;
        nRST     = 1'b0;
        EN       = 1'b0;
        CFG_LOAD = 1'b0;
        CLR_CNT  = 1'b0;
    endtask

    task automatic test_reset();
        logic xs [0:5];
        logic ys [0:5];
        logic as [0:5];
        logic e;
        xs = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ys = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        as = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        vectors++;
        if (Y !== e) begin
            miscompares++;
            $display("FAIL reset_y: got %b want %b", Y, e);
        end
        vectors++;
        if (MATCH_CNT !== 8'd0 || CFG_ERR !== 1'b0 || ARMED !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: cnt=%0d err=%b armed=%b want 0/0/0",
                     MATCH_CNT, CFG_ERR, ARMED);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, xs[i], 1'b0, 1'b0, ys[i]);
            e = exp_q.pop_front();
            vectors++;
            if (Y !== e || ARMED !== as[i]) begin
                miscompares++;
                $display("FAIL legacy[%0d]: Y=%b ARMED=%b want %b %b", i, Y, ARMED, e, as[i]);
            end
        end
        vectors++;
        if (MATCH_CNT !== 8'd2) begin
            miscompares++;
            $display("FAIL legacy_cnt: got %0d want 2", MATCH_CNT);
        end
    endtask

    task automatic test_enable_hold();
        logic ens [0:4];
        logic xs  [0:4];
        logic ys  [0:4];
        logic e;
        ens = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        xs  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        ys  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, ens[i], xs[i], 1'b0, 1'b0, ys[i]);
            e = exp_q.pop_front();
            vectors++;
            if (Y !== e) begin
                miscompares++;
                $display("FAIL en_hold[%0d]: Y=%b want %b", i, Y, e);
            end
        end
        vectors++;
        if (MATCH_CNT !== 8'd4) begin
            miscompares++;
            $display("FAIL en_hold_cnt: got %0d want 4", MATCH_CNT);
        end
    endtask

    task automatic test_overlap();
        logic xs [0:6];
        logic ys [0:6];
        logic e;
        xs = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        ys = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        CFG_PATTERN = 8'b0000_1011;
        CFG_LEN     = 4'd4;
        CFG_OVERLAP = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        e = exp_q.pop_front();
        vectors++;
        if (Y !== e || MATCH_CNT !== 8'd0 || ARMED !== 1'b0) begin
            miscompares++;
            $display("FAIL ovl_load: Y=%b cnt=%0d armed=%b want %b 0 0", Y, MATCH_CNT, ARMED, e);
        end
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, xs[i], 1'b0, 1'b0, ys[i]);
            e = exp_q.pop_front();
            vectors++;
            if (Y !== e) begin
                miscompares++;
                $display("FAIL ovl[%0d]: Y=%b want %b", i, Y, e);
            end
        end
        vectors++;
        if (MATCH_CNT !== 8'd2) begin
            miscompares++;
            $display("FAIL ovl_cnt: got %0d want 2", MATCH_CNT);
        end
    endtask

    task automatic test_non_overlap();
        logic xs [0:9];
        logic ys [0:9];
        logic as [0:9];
        logic e;
        xs = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        ys = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        as = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        CFG_OVERLAP = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        e = exp_q.pop_front();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, xs[i], 1'b0, 1'b0, ys[i]);
            e = exp_q.pop_front();
            vectors++;
            if (Y !== e || ARMED !== as[i]) begin
                miscompares++;
                $display("FAIL novl[%0d]: Y=%b ARMED=%b want %b %b", i, Y, ARMED, e, as[i]);
            end
            if (i == 6) begin
                vectors++;
                if (MATCH_CNT !== 8'd1) begin
                    miscompares++;
                    $display("FAIL novl_cnt_mid: got %0d want 1", MATCH_CNT);
                end
            end
        end
        vectors++;
        if (MATCH_CNT !== 8'd2) begin
            miscompares++;
            $display("FAIL novl_cnt: got %0d want 2", MATCH_CNT);
        end
    endtask

    task automatic test_cfg_err();
        logic xs [0:3];
        logic ys [0:3];
        logic e;
        xs = '{1'b1, 1'b0, 1'b1, 1'b1};
        ys = '{1'b0, 1'b0, 1'b0, 1'b1};
        CFG_PATTERN = 8'hFF;
        CFG_OVERLAP = 1'b1;
        CFG_LEN     = 4'd0;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        vectors++;
        if (CFG_ERR !== 1'b1 || Y !== e) begin
            miscompares++;
            $display("FAIL err_len0: err=%b Y=%b want 1 %b", CFG_ERR, Y, e);
        end
        CFG_LEN = 4'(MAX_LEN + 1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        vectors++;
        if (CFG_ERR !== 1'b1 || Y !== e) begin
            miscompares++;
            $display("FAIL err_len9: err=%b Y=%b want 1 %b", CFG_ERR, Y, e);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, xs[i], 1'b0, 1'b0, ys[i]);
            e = exp_q.pop_front();
            vectors++;
            if (Y !== e) begin
                miscompares++;
                $display("FAIL err_keep_cfg[%0d]: Y=%b want %b", i, Y, e);
            end
        end
        // Legal load keeps the sticky flag; pattern bits above LEN are ignored.
        CFG_PATTERN = 8'b1111_0101;
        CFG_LEN     = 4'd3;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        vectors++;
        if (CFG_ERR !== 1'b1 || ARMED !== 1'b0) begin
            miscompares++;
            $display("FAIL err_sticky: err=%b armed=%b want 1 0", CFG_ERR, ARMED);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, (i != 1), 1'b0, 1'b0, (i == 2));
            e = exp_q.pop_front();
            vectors++;
            if (Y !== e) begin
                miscompares++;
                $display("FAIL upper_bits_ignored[%0d]: Y=%b want %b", i, Y, e);
            end
        end
    endtask

    task automatic test_saturation();
        logic e;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        vectors++;
        if (CFG_ERR !== 1'b0 || err_s !== 1'b0 || armed_s !== 1'b0 || Y !== e) begin
            miscompares++;
            $display("FAIL sat_reset: err=%b err_s=%b armed_s=%b Y=%b want 0 0 0 %b",
                     CFG_ERR, err_s, armed_s, Y, e);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, (i >= 2));
            e = exp_q.pop_front();
            vectors++;
            if (Y !== e) begin
                miscompares++;
                $display("FAIL sat_stream[%0d]: Y=%b want %b", i, Y, e);
            end
        end
        vectors++;
        if (MATCH_CNT !== 8'd6 || cnt_s !== 2'd3) begin
            miscompares++;
            $display("FAIL sat_cnt: cnt=%0d cnt_s=%0d want 6 3", MATCH_CNT, cnt_s);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        e = exp_q.pop_front();
        vectors++;
        if (Y !== e || y_s !== e || MATCH_CNT !== 8'd1 || cnt_s !== 2'd1) begin
            miscompares++;
            $display("FAIL clr_with_match: Y=%b y_s=%b cnt=%0d cnt_s=%0d want %b %b 1 1",
                     Y, y_s, MATCH_CNT, cnt_s, e, e);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        e = exp_q.pop_front();
        vectors++;
        if (Y !== e || MATCH_CNT !== 8'd0 || cnt_s !== 2'd0) begin
            miscompares++;
            $display("FAIL clr_plain: Y=%b cnt=%0d cnt_s=%0d want %b 0 0", Y, MATCH_CNT, cnt_s, e);
        end
    endtask

    task automatic test_midstream_reset();
        logic e;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            e = exp_q.pop_front();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        vectors++;
        if (Y !== e || ARMED !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: Y=%b ARMED=%b want %b 0", Y, ARMED, e);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, (i == 2));
            e = exp_q.pop_front();
            vectors++;
            if (Y !== e) begin
                miscompares++;
                $display("FAIL refill_after_reset[%0d]: Y=%b want %b", i, Y, e);
            end
        end
        CFG_PATTERN = 8'b0000_0111;
        CFG_LEN     = 4'd3;
        CFG_OVERLAP = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        vectors++;
        if (Y !== e || ARMED !== 1'b0) begin
            miscompares++;
            $display("FAIL load_drops_sample: Y=%b ARMED=%b want %b 0", Y, ARMED, e);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, (i == 2));
            e = exp_q.pop_front();
            vectors++;
            if (Y !== e) begin
                miscompares++;
                $display("FAIL refill_after_load[%0d]: Y=%b want %b", i, Y, e);
            end
        end
    endtask

    initial begin
        nRST        = 1'b1;
        EN          = 1'b0;
        X           = 1'b0;
        CFG_LOAD    = 1'b0;
        CFG_PATTERN = '0;
        CFG_LEN     = '0;
        CFG_OVERLAP = 1'b0;
        CLR_CNT     = 1'b0;
        #2;
        test_reset();
        test_enable_hold();
        test_overlap();
        test_non_overlap();
        test_cfg_err();
        test_saturation();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pattern_detector_p.md
Name: pattern_detector_p

Overview:
Parametrised serial pattern detector, successor to the fixed three-ones detector.
- Compares a serial bit stream X, qualified by EN, against a runtime-programmable pattern of 1..MAX_LEN bits.
- Overlapping or non-overlapping matching.
- Registered match pulse Y plus a saturating match counter.
- Reset configuration (LEN=3, pattern 111, overlap) gives the same cycle behaviour as the legacy detector when EN=1.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (legal range 3..32).
CNT_W, 8, width of the match counter.
LEN_W, $clog2(MAX_LEN+1), width of the length fields (derived; do not override).

Ports:
CLK  input  1  clock, all logic on rising edge
nRST  input  1  reset, synchronous, active-high
EN  input  1  sample valid; X is consumed only on cycles with EN=1
X  input  1  serial data bit
CFG_LOAD  input  1  one-cycle strobe that latches CFG_* fields
CFG_PATTERN  input  MAX_LEN  pattern; bit CFG_LEN-1 is the oldest bit, bit 0 the newest
CFG_LEN  input  LEN_W  pattern length
CFG_OVERLAP  input  1  1 = overlapping matches, 0 = non-overlapping
CLR_CNT  input  1  synchronous clear of MATCH_CNT
Y  output  1  match pulse
MATCH_CNT  output  CNT_W  saturating count of matches
CFG_ERR  output  1  sticky flag for an illegal configuration
ARMED  output  1  1 when the history holds at least LEN valid bits

Behaviour:
- Reset (nRST=1 at a clock edge):
  - Outputs: Y=0, MATCH_CNT=0, CFG_ERR=0, ARMED=0.
  - Internal state: hist=0, fill=0, state FILL.
  - Configuration: LEN=3, PATTERN low 3 bits = 111 (others 0), OVERLAP=1.
- Internal state:
  - hist[MAX_LEN-1:0] shift register.
  - fill counter, saturating at MAX_LEN.
  - latched LEN, PATTERN, OVERLAP.
- FSM states: FILL (fill<LEN), ARMED (fill>=LEN). ARMED output = (state==ARMED).
- Accepted sample (EN=1, CFG_LOAD=0):
  - hist <= {hist[MAX_LEN-2:0], X}.
  - fill <= min(fill+1, MAX_LEN).
- Match condition, evaluated on the post-shift history:
  - fill_next>=LEN and hist_next[LEN-1:0]==PATTERN[LEN-1:0].
  - Bits above LEN-1 are ignored.
- On a match:
  - Y=1 in the cycle after the accepted sample, for exactly one cycle.
  - MATCH_CNT increments, saturating at 2^CNT_W-1.
  - OVERLAP=0: fill <= 0 and state returns to FILL, so the next match needs LEN fresh bits.
  - OVERLAP=1: fill is kept, so consecutive matches are possible on consecutive samples.
- Y is 0 in the cycle after any cycle with EN=0. History and fill hold while EN=0.
- CFG_LOAD=1:
  - If 1<=CFG_LEN<=MAX_LEN: latch PATTERN, LEN, OVERLAP; clear hist and fill; state FILL; Y=0. CFG_ERR is not cleared.
  - Otherwise: configuration is unchanged, CFG_ERR <= 1 (sticky until reset), and hist and fill are also unchanged.
  - CFG_LOAD has priority over EN; the concurrent sample is dropped.
- CLR_CNT=1: MATCH_CNT <= 0. If a match occurs in the same cycle, MATCH_CNT <= 1 (clear, then count). Y is unaffected.
- Reset in mid-stream discards history and configuration, reverting to the defaults, on that edge; it has priority over everything.
- Legacy equivalence, defaults with EN held 1: Y goes high after the third consecutive 1, stays high while 1s continue, and drops the cycle after a 0 is sampled.

Decomposition:
- Package pattern_detector_pkg holds:
  - state enum {FILL, ARMED};
  - DEFAULT_LEN=3;
  - DEFAULT_OVERLAP=1'b1;
  - a function that builds the compare mask from LEN.
- One sub-module, pd_history: shift register plus saturating fill counter, with inputs shift_en and clr. The top level keeps the configuration registers, comparator, FSM, counter and error logic.

Test Plan:
1. Reset defaults, EN=1, X=0,1,1,1,1,0 -> Y=0,0,0,1,1,0 aligned one cycle after each sample; MATCH_CNT=2.
2. Load LEN=4, PATTERN=1011, OVERLAP=1; X=1,0,1,1,0,1,1 -> Y pulses after samples 4 and 7; MATCH_CNT=2.
3. Same pattern with OVERLAP=0 -> Y pulses only after sample 4; MATCH_CNT=1; ARMED drops after the match.
4. CFG_LEN=0, then CFG_LEN=MAX_LEN+1 -> CFG_ERR=1 both times, config still LEN=4; a stream 1011 still matches.
5. CNT_W=2 build, six matches -> MATCH_CNT saturates at 3. CLR_CNT concurrent with a match -> MATCH_CNT=1.
6. nRST=1 after two accepted 1s, then X=1 -> no Y (fill restarted). CFG_LOAD with EN=1 and X=1 -> sample dropped, fill=0.
